// File: rtl/register_file_scoreboard_if.sv
// rtl/register_file_scoreboard_if.sv - read/write/scoreboard bus of the register file
//
// Purpose: groups every non-clock, non-reset signal of register_file_scoreboard.
// Ports (signals):
//   rd_addr   NUM_RD*ADDR_SIZE  read addresses, port k at [k*ADDR_SIZE +: ADDR_SIZE]
//   rd_data   NUM_RD*BUS_WIDTH  read data, port k at [k*BUS_WIDTH +: BUS_WIDTH]
//   rd_busy   NUM_RD            busy flag of the register each read port addresses
//   wr0_*     write port 0 (lower priority)
//   wr1_*     write port 1 (higher priority)
//   set_busy_en / set_busy_addr  mark a destination register pending
//   busy_vec  DEPTH             registered scoreboard
// Modports: master = decode/issue side, slave = register file.
interface register_file_scoreboard_if #(
  parameter int BUS_WIDTH = 16,
  parameter int DEPTH     = 8,
  parameter int NUM_RD    = 2
);
  localparam int ADDR_SIZE = $clog2(DEPTH);

  logic [NUM_RD*ADDR_SIZE-1:0] rd_addr;
  logic [NUM_RD*BUS_WIDTH-1:0] rd_data;
  logic [NUM_RD-1:0]           rd_busy;
  logic                        wr0_en;
  logic [ADDR_SIZE-1:0]        wr0_addr;
  logic [BUS_WIDTH-1:0]        wr0_data;
  logic                        wr1_en;
  logic [ADDR_SIZE-1:0]        wr1_addr;
  logic [BUS_WIDTH-1:0]        wr1_data;
  logic                        set_busy_en;
  logic [ADDR_SIZE-1:0]        set_busy_addr;
  logic [DEPTH-1:0]            busy_vec;

  modport master (
    output rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
           set_busy_en, set_busy_addr,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
           set_busy_en, set_busy_addr,
    output rd_data, rd_busy, busy_vec
  );
endinterface

// File: rtl/register_file_scoreboard.sv
// rtl/register_file_scoreboard.sv - parametrised register file with busy scoreboard
//
// Purpose: DEPTH x BUS_WIDTH register file with NUM_RD combinational read ports,
// two prioritised write ports (wr1 wins on a shared address), optional hardwired
// zero register, optional write-to-read bypass, and a per-register busy bit used
// for RAW hazard tracking at issue.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset; clears registers and busy bits and
//        forces rd_data / rd_busy low while asserted
//   bus  register_file_scoreboard_if.slave (read ports, write ports, scoreboard)
module register_file_scoreboard #(
  parameter int BUS_WIDTH = 16,
  parameter int DEPTH     = 8,
  parameter int NUM_RD    = 2,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1
) (
  input logic                         clk,
  input logic                         rst,
  register_file_scoreboard_if.slave   bus
);
  localparam int ADDR_SIZE = $clog2(DEPTH);

  // One-hot decodes of each write port and of the set-busy request.
  logic [DEPTH-1:0] hit0;
  logic [DEPTH-1:0] hit1;
  logic [DEPTH-1:0] set_hit;

  always_comb begin
    hit0    = '0;
    hit1    = '0;
    set_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit0[i]    = bus.wr0_en      && (bus.wr0_addr      == ADDR_SIZE'(i));
      hit1[i]    = bus.wr1_en      && (bus.wr1_addr      == ADDR_SIZE'(i));
      set_hit[i] = bus.set_busy_en && (bus.set_busy_addr == ADDR_SIZE'(i));
    end
  end

  // Stored register values, one flop bank per register so register 0 can be
  // replaced by a constant when it is hardwired.
  logic [BUS_WIDTH-1:0] regs_q [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    if (ZERO_REG != 0 && i == 0) begin : g_zero
      assign regs_q[i] = '0;
    end else begin : g_live
      logic [BUS_WIDTH-1:0] data_q;
      logic [BUS_WIDTH-1:0] data_d;

      always_comb begin
        data_d = data_q;
        if (hit1[i]) begin
          data_d = bus.wr1_data;
        end else if (hit0[i]) begin
          data_d = bus.wr0_data;
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          data_q <= '0;
        end else begin
          data_q <= data_d;
        end
      end

      assign regs_q[i] = data_q;
    end
  end

  // Scoreboard: completing writes clear, issue sets. The set is OR-ed in after
  // the clear so a new producer overrides one completing in the same cycle.
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  always_comb begin
    busy_d = (busy_q & ~(hit0 | hit1)) | set_hit;
    if (ZERO_REG != 0) begin
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign bus.busy_vec = busy_q;

  // Read ports. Outputs are forced low during reset because the bypass path
  // would otherwise expose live write data while the state is held cleared.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_SIZE-1:0] addr;
    logic [BUS_WIDTH-1:0] data;
    logic                 busy;
    logic                 in_flight;

    assign addr = bus.rd_addr[k*ADDR_SIZE +: ADDR_SIZE];

    always_comb begin
      data      = regs_q[addr];
      in_flight = 1'b0;
      if (BYPASS != 0) begin
        if (hit1[addr]) begin
          data      = bus.wr1_data;
          in_flight = 1'b1;
        end else if (hit0[addr]) begin
          data      = bus.wr0_data;
          in_flight = 1'b1;
        end
      end
      if (ZERO_REG != 0 && addr == '0) begin
        data = '0;
      end
      // A write landing this cycle resolves the hazard for a bypassed reader.
      busy = in_flight ? 1'b0 : busy_q[addr];
      if (!rst) begin
        data = '0;
        busy = 1'b0;
      end
    end

    assign bus.rd_data[k*BUS_WIDTH +: BUS_WIDTH] = data;
    assign bus.rd_busy[k]                        = busy;
  end
endmodule
